// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer managers (write and read side).
package async_fifo_pkg;

    // Widest pointer the helpers handle; narrower pointers are zero-extended.
    localparam int unsigned PTR_MAX_W = 32;

    // Binary to Gray; zero-extension keeps the result valid for any width <= PTR_MAX_W.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary via XOR prefix from the MSB; zero upper bits leave the result unchanged.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = int'(PTR_MAX_W) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_gray2bin.sv
// Combinational Gray-to-binary converter for a synchronized pointer.
module async_fifo_gray2bin #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    logic [W-1:0] acc;

    // XOR prefix chain from the MSB down.
    always_comb begin
        acc        = '0;
        acc[W-1]   = gray[W-1];
        for (int i = int'(W) - 2; i >= 0; i--) begin
            acc[i] = acc[i+1] ^ gray[i];
        end
        bin = acc;
    end

endmodule

// File: rtl/async_fifo_wptr_full.sv
// Write-side pointer, full/almost-full, level and overflow tracking for the async FIFO.
module async_fifo_wptr_full
    import async_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned AFULL_THRESH = (1 << ADDR_W) - 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rd_ptr_gray_sync,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_inc,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic              wr_full,
    output logic              wr_almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              wr_overflow
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    // Inverting the top two Gray bits of the read pointer yields the "full" write pointer.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (ADDR_W - 1);

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] full_cmp;
    logic [PTR_W-1:0] level_next;

    async_fifo_gray2bin #(
        .W (PTR_W)
    ) u_rptr_g2b (
        .gray (rd_ptr_gray_sync),
        .bin  (rbin)
    );

    // Next-state pointer arithmetic; level uses the new write and read pointers together.
    assign wr_inc     = wr_en & ~wr_full;
    assign wbin_next  = wbin + PTR_W'(wr_inc);
    assign wgray_next = PTR_W'(bin2gray(PTR_MAX_W'(wbin_next)));
    assign full_cmp   = rd_ptr_gray_sync ^ FULL_MASK;
    assign level_next = wbin_next - rbin;
    assign wr_addr    = wbin[ADDR_W-1:0];

    // Pointer and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbin           <= '0;
            wr_ptr_gray    <= '0;
            wr_full        <= 1'b0;
            wr_almost_full <= 1'b0;
            wr_level       <= '0;
            wr_overflow    <= 1'b0;
        end else begin
            wbin           <= wbin_next;
            wr_ptr_gray    <= wgray_next;
            wr_full        <= (wgray_next == full_cmp);
            wr_almost_full <= (level_next >= PTR_W'(AFULL_THRESH));
            wr_level       <= level_next;
            wr_overflow    <= wr_en & wr_full;
        end
    end

`ifdef ASSERT_ON
    generate
        if (ADDR_W < 1) begin : g_bad_addr_w
            $fatal(1, "async_fifo_wptr_full: ADDR_W must be >= 1");
        end
        if ((AFULL_THRESH < 1) || (AFULL_THRESH > (1 << ADDR_W))) begin : g_bad_afull
            $fatal(1, "async_fifo_wptr_full: AFULL_THRESH out of range");
        end
    endgenerate

    logic [PTR_W-1:0] rgray_q;

    // The synchronized read pointer may move by at most one Gray bit per clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgray_q <= '0;
        end else begin
            rgray_q <= rd_ptr_gray_sync;
            assert ($countones(rgray_q ^ rd_ptr_gray_sync) <= 1)
                else $error("async_fifo_wptr_full: rd_ptr_gray_sync changed by more than one bit");
        end
    end
`endif

endmodule
